// File: rtl/uart_cmd_decoder_if.sv
// Bundle of the UART-facing and button-facing signals of uart_cmd_decoder.
// The decoder connects through the slave modport; whatever drives the UART
// side (the receiver/transmitter glue or a bench) uses the master modport.
interface uart_cmd_decoder_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       btn_up;
    logic       btn_left;
    logic       btn_right;
    logic       btn_start;
    logic [7:0] bad_cnt;
    logic       tx_start;
    logic [7:0] tx_data;

    modport slave (
        input  rx_done,
        input  rx_data,
        input  tx_ready,
        output btn_up,
        output btn_left,
        output btn_right,
        output btn_start,
        output bad_cnt,
        output tx_start,
        output tx_data
    );

    modport master (
        output rx_done,
        output rx_data,
        output tx_ready,
        input  btn_up,
        input  btn_left,
        input  btn_right,
        input  btn_start,
        input  bad_cnt,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received keystroke bytes into held button
// requests (up/left/right), a one-cycle start pulse and a saturating count
// of unrecognised bytes.
// Optional feature macro: UART_CMD_ECHO_EN -- when defined, every recognised
// byte is echoed back to the UART transmitter through a one-entry pending
// buffer; when undefined, tx_start/tx_data are tied low and no echo logic
// exists.
module uart_cmd_decoder #(
    parameter int unsigned HOLD_CYCLES = 10_000_000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_cmd_decoder_if.slave     bus
);

    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_UP,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_START,
        CMD_RELEASE,
        CMD_BAD
    } cmd_e;

    cmd_e cmd;

    logic [CNT_W-1:0] up_cnt_q,    up_cnt_d;
    logic [CNT_W-1:0] left_cnt_q,  left_cnt_d;
    logic [CNT_W-1:0] right_cnt_q, right_cnt_d;
    logic             btn_up_q,    btn_up_d;
    logic             btn_left_q,  btn_left_d;
    logic             btn_right_q, btn_right_d;
    logic             btn_start_q, btn_start_d;
    logic [7:0]       bad_cnt_q,   bad_cnt_d;

    // Classify the incoming byte; nothing is decoded unless rx_done strobes.
    always_comb begin
        cmd = CMD_NONE;
        if (bus.rx_done) begin
            case (bus.rx_data)
                8'h57, 8'h77: cmd = CMD_UP;
                8'h41, 8'h61: cmd = CMD_LEFT;
                8'h44, 8'h64: cmd = CMD_RIGHT;
                8'h53, 8'h73: cmd = CMD_START;
                8'h20:        cmd = CMD_RELEASE;
                default:      cmd = CMD_BAD;
            endcase
        end
    end

    // Hold counters, button levels, start pulse and bad-byte counter.
    // The button flops take (next counter != 0) so they track the counters
    // exactly while still being registered outputs.
    always_comb begin
        up_cnt_d    = (up_cnt_q    != '0) ? up_cnt_q    - ONE_VAL : up_cnt_q;
        left_cnt_d  = (left_cnt_q  != '0) ? left_cnt_q  - ONE_VAL : left_cnt_q;
        right_cnt_d = (right_cnt_q != '0) ? right_cnt_q - ONE_VAL : right_cnt_q;
        btn_start_d = 1'b0;
        bad_cnt_d   = bad_cnt_q;

        // A load overrides the decrement, so a byte arriving as a counter
        // expires reloads it without a low gap.
        case (cmd)
            CMD_UP: begin
                up_cnt_d = HOLD_VAL;
            end
            CMD_LEFT: begin
                left_cnt_d  = HOLD_VAL;
                right_cnt_d = '0;
            end
            CMD_RIGHT: begin
                right_cnt_d = HOLD_VAL;
                left_cnt_d  = '0;
            end
            CMD_START: begin
                btn_start_d = 1'b1;
            end
            CMD_RELEASE: begin
                up_cnt_d    = '0;
                left_cnt_d  = '0;
                right_cnt_d = '0;
            end
            CMD_BAD: begin
                if (bad_cnt_q != 8'hFF) begin
                    bad_cnt_d = bad_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase

        btn_up_d    = (up_cnt_d    != '0);
        btn_left_d  = (left_cnt_d  != '0);
        btn_right_d = (right_cnt_d != '0);
    end

    // Decoder state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_cnt_q    <= '0;
            left_cnt_q  <= '0;
            right_cnt_q <= '0;
            btn_up_q    <= 1'b0;
            btn_left_q  <= 1'b0;
            btn_right_q <= 1'b0;
            btn_start_q <= 1'b0;
            bad_cnt_q   <= '0;
        end else begin
            up_cnt_q    <= up_cnt_d;
            left_cnt_q  <= left_cnt_d;
            right_cnt_q <= right_cnt_d;
            btn_up_q    <= btn_up_d;
            btn_left_q  <= btn_left_d;
            btn_right_q <= btn_right_d;
            btn_start_q <= btn_start_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign bus.btn_up    = btn_up_q;
    assign bus.btn_left  = btn_left_q;
    assign bus.btn_right = btn_right_q;
    assign bus.btn_start = btn_start_q;
    assign bus.bad_cnt   = bad_cnt_q;

`ifdef UART_CMD_ECHO_EN
    typedef enum logic {
        E_IDLE,
        E_PEND
    } echo_state_e;

    echo_state_e echo_state_q, echo_state_d;
    logic [7:0]  pend_q,       pend_d;
    logic        tx_start_q,   tx_start_d;
    logic [7:0]  tx_data_q,    tx_data_d;
    logic        accepted;

    assign accepted = (cmd != CMD_NONE) && (cmd != CMD_BAD);

    // Echo FSM: send at once when the transmitter is free, otherwise park
    // the newest byte. A pulse in the previous cycle counts as "busy" so
    // tx_start can never be high two cycles running.
    always_comb begin
        echo_state_d = echo_state_q;
        pend_d       = pend_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;

        case (echo_state_q)
            E_IDLE: begin
                if (accepted) begin
                    if (bus.tx_ready && !tx_start_q) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = bus.rx_data;
                    end else begin
                        pend_d       = bus.rx_data;
                        echo_state_d = E_PEND;
                    end
                end
            end
            E_PEND: begin
                // A byte arriving in the send cycle replaces the parked one.
                if (bus.tx_ready) begin
                    tx_start_d   = 1'b1;
                    tx_data_d    = accepted ? bus.rx_data : pend_q;
                    echo_state_d = E_IDLE;
                end else if (accepted) begin
                    pend_d = bus.rx_data;
                end
            end
            default: echo_state_d = E_IDLE;
        endcase
    end

    // Echo state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_state_q <= E_IDLE;
            pend_q       <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            echo_state_q <= echo_state_d;
            pend_q       <= pend_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
`else
    assign bus.tx_start = 1'b0;
    assign bus.tx_data  = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder (HOLD_CYCLES=16, CNT_W=8).
// Expected button/counter values are queued per cycle as bytes are driven
// and compared on the falling edge; expected echo bytes are queued in send
// order and popped whenever tx_start is seen.
module tb_uart_cmd_decoder;

    localparam int unsigned HOLD = 16;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_cmd_decoder_if bus_if ();

    uart_cmd_decoder #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef enum int {SIG_UP, SIG_LEFT, SIG_RIGHT, SIG_START, SIG_BAD} sig_e;
    typedef struct {
        int   cyc;
        sig_e sig;
        int   val;
    } want_t;

    want_t      want_q[$];
    logic [7:0] echo_q[$];
    logic       prev_tx_start = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp_v);
        end
    endtask

    function automatic int sig_val(input sig_e s);
        case (s)
            SIG_UP:    return int'(bus_if.btn_up);
            SIG_LEFT:  return int'(bus_if.btn_left);
            SIG_RIGHT: return int'(bus_if.btn_right);
            SIG_START: return int'(bus_if.btn_start);
            default:   return int'(bus_if.bad_cnt);
        endcase
    endfunction

    function automatic string sig_name(input sig_e s);
        case (s)
            SIG_UP:    return "btn_up";
            SIG_LEFT:  return "btn_left";
            SIG_RIGHT: return "btn_right";
            SIG_START: return "btn_start";
            default:   return "bad_cnt";
        endcase
    endfunction

    function automatic void want(input int c0, input int c1, input sig_e s, input int v);
        for (int c = c0; c <= c1; c++) begin
            want_t w;
            w.cyc = c;
            w.sig = s;
            w.val = v;
            want_q.push_back(w);
        end
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int n, input logic [7:0] b);
        wait_cyc(n);
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = b;
        @(posedge clk);
        #1;
        bus_if.rx_done = 1'b0;
        bus_if.rx_data = 8'h7E;
    endtask

    // Scoreboard compare, exclusivity and echo monitors on the falling edge.
    always @(negedge clk) begin
        for (int i = want_q.size() - 1; i >= 0; i--) begin
            if (want_q[i].cyc == cyc) begin
                check_eq(sig_name(want_q[i].sig), sig_val(want_q[i].sig), want_q[i].val);
                want_q.delete(i);
            end
        end
        check_eq("left_right_excl", int'(bus_if.btn_left & bus_if.btn_right), 0);
`ifdef UART_CMD_ECHO_EN
        if (bus_if.tx_start) begin
            check_eq("tx_consec", int'(prev_tx_start), 0);
            check_eq("echo_expected", int'(echo_q.size() > 0), 1);
            if (echo_q.size() > 0) begin
                check_eq("echo_data", int'(bus_if.tx_data), int'(echo_q.pop_front()));
            end
        end
`else
        check_eq("tx_start_off", int'(bus_if.tx_start), 0);
        check_eq("tx_data_off", int'(bus_if.tx_data), 0);
`endif
        prev_tx_start = bus_if.tx_start;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus_if.rx_done  = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.tx_ready = 1'b0;

        // Reset state.
        wait_cyc(1);
        #3;
        check_eq("rst_btn_up",    int'(bus_if.btn_up),    0);
        check_eq("rst_btn_left",  int'(bus_if.btn_left),  0);
        check_eq("rst_btn_right", int'(bus_if.btn_right), 0);
        check_eq("rst_btn_start", int'(bus_if.btn_start), 0);
        check_eq("rst_bad_cnt",   int'(bus_if.bad_cnt),   0);
        check_eq("rst_tx_start",  int'(bus_if.tx_start),  0);
        check_eq("rst_tx_data",   int'(bus_if.tx_data),   0);
        wait_cyc(3);
        reset = 1'b0;

        // 'w' at 10 -> up high 11..26, low at 27.
        want(10, 10, SIG_UP, 0);
        want(11, 10 + HOLD, SIG_UP, 1);
        want(11 + HOLD, 11 + HOLD, SIG_UP, 0);
        send(10, 8'h77);

        // 'a' at 40, 'D' at 44 -> left 41..44, right from 45.
        want(41, 44, SIG_LEFT, 1);
        want(41, 44, SIG_RIGHT, 0);
        want(45, 45, SIG_LEFT, 0);
        want(45, 44 + HOLD, SIG_RIGHT, 1);
        want(45 + HOLD, 45 + HOLD, SIG_RIGHT, 0);
        send(40, 8'h61);
        send(44, 8'h44);

        // 'd' at 70, again at 86 when the counter would hit 0: no gap.
        want(71, 86 + HOLD, SIG_RIGHT, 1);
        want(87 + HOLD, 87 + HOLD, SIG_RIGHT, 0);
        send(70, 8'h64);
        send(86, 8'h64);

        // 'a' at 108, 'w' at 110, space at 113: up and left coexist, all drop at 114.
        want(111, 113, SIG_LEFT, 1);
        want(111, 113, SIG_UP, 1);
        want(114, 114, SIG_UP, 0);
        want(114, 114, SIG_LEFT, 0);
        want(114, 114, SIG_RIGHT, 0);
        send(108, 8'h61);
        send(110, 8'h77);
        send(113, 8'h20);

        // 'W' at 120 then 300 bad bytes 121..420: counter saturates, up unaffected.
        want(120, 120, SIG_BAD, 0);
        want(121, 120 + HOLD, SIG_UP, 1);
        want(121 + HOLD, 121 + HOLD, SIG_UP, 0);
        want(122, 122, SIG_BAD, 1);
        want(300, 300, SIG_BAD, 179);
        want(376, 376, SIG_BAD, 255);
        want(421, 421, SIG_BAD, 255);
        send(120, 8'h57);
        wait_cyc(121);
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = 8'h7E;
        repeat (300) @(posedge clk);
        #1;
        bus_if.rx_done = 1'b0;

        // 'w' on rx_data without rx_done must be ignored.
        want(431, 436, SIG_UP, 0);
        want(436, 436, SIG_BAD, 255);
        wait_cyc(430);
        bus_if.rx_data = 8'h57;
        wait_cyc(435);
        bus_if.rx_data = 8'h7E;

        // 's' at 450 pulses start; 'd' at 455 holds, 'S' at 460 leaves it alone.
        want(450, 450, SIG_START, 0);
        want(451, 451, SIG_START, 1);
        want(452, 452, SIG_START, 0);
        want(456, 455 + HOLD, SIG_RIGHT, 1);
        want(456 + HOLD, 456 + HOLD, SIG_RIGHT, 0);
        want(461, 461, SIG_START, 1);
        want(462, 462, SIG_START, 0);
        send(450, 8'h73);
        send(455, 8'h64);
        send(460, 8'h53);

        // 'w' at 480, reset mid-hold at 485: immediate drop, stays low after release.
        want(481, 484, SIG_UP, 1);
        send(480, 8'h77);
        wait_cyc(485);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_rst_btn_up",  int'(bus_if.btn_up),  0);
        check_eq("async_rst_bad_cnt", int'(bus_if.bad_cnt), 0);
        wait_cyc(488);
        reset = 1'b0;
        want(489, 500, SIG_UP, 0);
        want(489, 489, SIG_BAD, 0);

        // Byte strobed in the cycle reset deasserts is processed.
        wait_cyc(510);
        reset = 1'b1;
        want(513, 512 + HOLD, SIG_LEFT, 1);
        want(513 + HOLD, 513 + HOLD, SIG_LEFT, 0);
        wait_cyc(512);
        reset = 1'b0;
        send(512, 8'h61);

        // tx_ready low: 'a' then 'w' -> one echo of 0x77 once tx_ready rises.
`ifdef UART_CMD_ECHO_EN
        echo_q.push_back(8'h77);
`endif
        send(540, 8'h61);
        send(541, 8'h77);
        wait_cyc(550);
        bus_if.tx_ready = 1'b1;

        // Transmitter idle: direct echo, bad byte silent, back-to-back bytes spaced.
`ifdef UART_CMD_ECHO_EN
        echo_q.push_back(8'h44);
`endif
        send(560, 8'h44);
        send(565, 8'h7E);
`ifdef UART_CMD_ECHO_EN
        echo_q.push_back(8'h77);
        echo_q.push_back(8'h77);
`endif
        send(570, 8'h77);
        send(571, 8'h77);

        wait_cyc(600);
        check_eq("want_q_drained", want_q.size(), 0);
        check_eq("echo_q_drained", echo_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
